uart_rx_deframer: RTL and testbench

Serial-side receiver that decodes 8N1 UART frames from a single line into bytes and buffers them for the AHB-facing logic to read. It sits between the external `rxd` pin and the AHB-Lite UART register block, the receiving end of the frames the UART transmitter emits. The block handles start-bit qualification, mid-bit sampling on an oversampled baud tick, stop-bit checking, and a small show-ahead FIFO with overrun and framing-error reporting.

---
 rtl/uart_rx_deframer.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx_deframer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_deframer
// Description : 8N1 UART receiver. Synchronises rxd, qualifies the start bit,
//               samples each bit at its centre on an oversampled baud tick,
//               checks the stop bit and buffers bytes in a show-ahead FIFO
//               with overrun and framing-error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_deframer #(
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       baud_tick,
    input  logic       rxd,
    input  logic       rd_en,
    output logic [7:0] rdata,
    output logic       rx_empty,
    output logic       rx_full,
    output logic       frame_err,
    output logic       overrun
);

    localparam int c_tw = $clog2(OVERSAMPLE);
    localparam int c_pw = $clog2(FIFO_DEPTH);
    localparam int c_cw = c_pw + 1;

    localparam logic [c_tw-1:0] c_half_last = c_tw'(OVERSAMPLE / 2 - 1);
    localparam logic [c_tw-1:0] c_bit_last  = c_tw'(OVERSAMPLE - 1);
    localparam logic [c_tw-1:0] c_tcnt_one  = c_tw'(1);
    localparam logic [c_pw-1:0] c_ptr_one   = c_pw'(1);
    localparam logic [c_cw-1:0] c_cnt_one   = c_cw'(1);
    localparam logic [c_cw-1:0] c_depth     = c_cw'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } state_t;

    logic            rxd_m_q, rxd_s_q;
    state_t          state_q, state_d;
    logic [c_tw-1:0] tcnt_q, tcnt_d;
    logic [2:0]      bcnt_q, bcnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic [c_pw-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_pw-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cw-1:0] count_q, count_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic            w_push_req;
    logic            w_push_ok;
    logic            w_pop;
    logic            w_empty;
    logic            w_full;

    // Frame decoder: advances only on baud ticks, except IDLE/WAIT_HIGH
    // which follow the synchronised line every cycle.
    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        bcnt_d      = bcnt_q;
        shift_d     = shift_q;
        w_push_req  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rxd_s_q) begin
                    state_d = ST_START;
                    tcnt_d  = '0;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    if (tcnt_q == c_half_last) begin
                        tcnt_d  = '0;
                        bcnt_d  = '0;
                        // A line that is high again at mid-start was a glitch.
                        state_d = rxd_s_q ? ST_IDLE : ST_DATA;
                    end else begin
                        tcnt_d = tcnt_q + c_tcnt_one;
                    end
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (tcnt_q == c_bit_last) begin
                        tcnt_d  = '0;
                        shift_d = {rxd_s_q, shift_q[7:1]};
                        if (bcnt_q == 3'd7) begin
                            state_d = ST_STOP;
                        end else begin
                            bcnt_d = bcnt_q + 3'd1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + c_tcnt_one;
                    end
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    if (tcnt_q == c_bit_last) begin
                        tcnt_d = '0;
                        if (rxd_s_q) begin
                            w_push_req = 1'b1;
                            state_d    = ST_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = ST_WAIT_HIGH;
                        end
                    end else begin
                        tcnt_d = tcnt_q + c_tcnt_one;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                // Hold off until the line recovers so a break is one error.
                if (rxd_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO control: a push into a full FIFO succeeds only alongside a pop.
    always_comb begin
        w_empty   = (count_q == '0);
        w_full    = (count_q == c_depth);
        w_pop     = rd_en & ~w_empty;
        w_push_ok = w_push_req & (~w_full | rd_en);
        overrun_d = w_push_req & w_full & ~rd_en;
        wr_ptr_d  = w_push_ok ? (wr_ptr_q + c_ptr_one) : wr_ptr_q;
        rd_ptr_d  = w_pop ? (rd_ptr_q + c_ptr_one) : rd_ptr_q;
        case ({w_push_ok, w_pop})
            2'b10:   count_d = count_q + c_cnt_one;
            2'b01:   count_d = count_q - c_cnt_one;
            default: count_d = count_q;
        endcase
    end

    // State, counters, synchroniser and pulse outputs.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rxd_m_q     <= 1'b1;
            rxd_s_q     <= 1'b1;
            state_q     <= ST_IDLE;
            tcnt_q      <= '0;
            bcnt_q      <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            rxd_m_q     <= rxd;
            rxd_s_q     <= rxd_m_q;
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            bcnt_q      <= bcnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Storage array; contents are don't-care while the count says empty.
    always_ff @(posedge HCLK) begin
        if (!HRESET && w_push_ok) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign rdata     = (count_q == '0) ? 8'h00 : mem_q[rd_ptr_q];
    assign rx_empty  = (count_q == '0);
    assign rx_full   = (count_q == c_depth);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_deframer
// Description : Directed self-checking bench for uart_rx_deframer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_deframer;

    logic       HCLK;
    logic       HRESET;
    logic       baud_tick;
    logic       rxd;
    logic       rd_en;
    logic [7:0] rdata;
    logic       rx_empty;
    logic       rx_full;
    logic       frame_err;
    logic       overrun;

    int checks   = 0;
    int failures = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    logic [1:0] tdiv = 2'd0;

    uart_rx_deframer #(
        .OVERSAMPLE (16),
        .FIFO_DEPTH (4)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .baud_tick (baud_tick),
        .rxd       (rxd),
        .rd_en     (rd_en),
        .rdata     (rdata),
        .rx_empty  (rx_empty),
        .rx_full   (rx_full),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // One baud tick every fourth clock, changed on the falling edge.
    initial begin
        baud_tick = 1'b0;
        forever begin
            @(negedge HCLK);
            tdiv      = tdiv + 2'd1;
            baud_tick = (tdiv == 2'd0);
        end
    end

    // Count cycles on which each pulse output is high.
    always @(negedge HCLK) begin
        if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
        if (overrun === 1'b1)   ov_cnt <= ov_cnt + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Wait for n baud-tick clock edges, return 1ns after the last one.
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge HCLK); while (baud_tick !== 1'b1);
        end
        #1;
    endtask

    // Send one 8N1 frame, 16 ticks per bit; assumes tick alignment.
    // When rd_at_push is set, rd_en is pulsed on the stop-bit centre tick.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic rd_at_push);
        rxd = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            wait_ticks(16);
        end
        rxd = stop;
        if (rd_at_push) begin
            wait_ticks(7);
            do begin
                @(negedge HCLK);
                #1;
            end while (baud_tick !== 1'b1);
            rd_en = 1'b1;
            @(posedge HCLK);
            #1;
            rd_en = 1'b0;
            wait_ticks(8);
        end else begin
            wait_ticks(16);
        end
        rxd = 1'b1;
    endtask

    // Check the FIFO head then pop it.
    task automatic read_check(input logic [7:0] exp, input string name);
        @(negedge HCLK);
        checks++;
        if (rdata !== exp || rx_empty !== 1'b0) begin
            failures++;
            $display("FAIL %s: rdata=%h empty=%b, expected rdata=%h empty=0", name, rdata, rx_empty, exp);
        end
        rd_en = 1'b1;
        @(negedge HCLK);
        rd_en = 1'b0;
    endtask

    task automatic check_empty(input string name);
        checks++;
        if (rx_empty !== 1'b1 || rdata !== 8'h00 || rx_full !== 1'b0) begin
            failures++;
            $display("FAIL %s: empty=%b rdata=%h full=%b, expected empty=1 rdata=00 full=0", name, rx_empty, rdata, rx_full);
        end
    endtask

    task automatic test_reset;
        rxd    = 1'b1;
        rd_en  = 1'b0;
        HRESET = 1'b1;
        repeat (3) @(negedge HCLK);
        checks++;
        if (rdata !== 8'h00 || rx_empty !== 1'b1 || rx_full !== 1'b0 ||
            frame_err !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: rdata=%h empty=%b full=%b fe=%b ov=%b, expected 00 1 0 0 0",
                     rdata, rx_empty, rx_full, frame_err, overrun);
        end
        HRESET = 1'b0;
        wait_ticks(4);
        check_empty("post_reset_idle");
    endtask

    task automatic test_single_frame;
        send_frame(8'hA5, 1'b1, 1'b0);
        read_check(8'hA5, "frame_a5");
        @(negedge HCLK);
        check_empty("a5_popped");
        wait_ticks(4);
    endtask

    task automatic test_glitch;
        int fe0, ov0;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        rxd = 1'b0;
        wait_ticks(4);
        rxd = 1'b1;
        wait_ticks(30);
        checks++;
        if (rx_empty !== 1'b1 || fe_cnt != fe0 || ov_cnt != ov0) begin
            failures++;
            $display("FAIL glitch_ignored: empty=%b fe_pulses=%0d ov_pulses=%0d, expected 1 0 0",
                     rx_empty, fe_cnt - fe0, ov_cnt - ov0);
        end
        send_frame(8'h3C, 1'b1, 1'b0);
        read_check(8'h3C, "frame_3c_after_glitch");
        wait_ticks(4);
    endtask

    task automatic test_frame_error;
        int fe0;
        fe0 = fe_cnt;
        send_frame(8'h55, 1'b0, 1'b0);
        rxd = 1'b0;
        wait_ticks(24);
        rxd = 1'b1;
        wait_ticks(16);
        checks++;
        if (fe_cnt - fe0 != 1) begin
            failures++;
            $display("FAIL frame_err_pulse: pulse cycles=%0d, expected 1", fe_cnt - fe0);
        end
        check_empty("frame_err_discard");
        send_frame(8'h0F, 1'b1, 1'b0);
        read_check(8'h0F, "frame_0f_after_break");
        wait_ticks(4);
    endtask

    task automatic test_back_to_back;
        int ov0;
        ov0 = ov_cnt;
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0);
        checks++;
        if (rx_full !== 1'b1 || ov_cnt != ov0) begin
            failures++;
            $display("FAIL full_after_four: full=%b ov_pulses=%0d, expected 1 0", rx_full, ov_cnt - ov0);
        end
        send_frame(8'h05, 1'b1, 1'b0);
        checks++;
        if (ov_cnt - ov0 != 1 || rx_full !== 1'b1) begin
            failures++;
            $display("FAIL overrun_on_fifth: ov_pulses=%0d full=%b, expected 1 1", ov_cnt - ov0, rx_full);
        end
        for (int i = 1; i <= 4; i++) read_check(8'(i), "b2b_read");
        @(negedge HCLK);
        check_empty("b2b_drained");
        wait_ticks(4);
    endtask

    task automatic test_push_with_pop;
        int ov0;
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0);
        ov0 = ov_cnt;
        send_frame(8'h99, 1'b1, 1'b1);
        checks++;
        if (ov_cnt != ov0 || rx_full !== 1'b1) begin
            failures++;
            $display("FAIL push_with_pop: ov_pulses=%0d full=%b, expected 0 1", ov_cnt - ov0, rx_full);
        end
        read_check(8'h02, "pp_read2");
        read_check(8'h03, "pp_read3");
        read_check(8'h04, "pp_read4");
        read_check(8'h99, "pp_read99");
        @(negedge HCLK);
        check_empty("pp_drained");
        wait_ticks(4);
    endtask

    task automatic test_reset_mid_frame;
        int fe0, ov0;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        rxd = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 3; i++) begin
            rxd = i[0];
            wait_ticks(16);
        end
        @(negedge HCLK);
        HRESET = 1'b1;
        rxd    = 1'b1;
        @(negedge HCLK);
        HRESET = 1'b0;
        check_empty("reset_mid_frame");
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        wait_ticks(180);
        checks++;
        if (rx_empty !== 1'b1 || fe_cnt != fe0 || ov_cnt != ov0) begin
            failures++;
            $display("FAIL no_spurious_after_reset: empty=%b fe_pulses=%0d ov_pulses=%0d, expected 1 0 0",
                     rx_empty, fe_cnt - fe0, ov_cnt - ov0);
        end
        send_frame(8'hC3, 1'b1, 1'b0);
        read_check(8'hC3, "frame_c3_after_reset");
    endtask

    initial begin
        HRESET = 1'b1;
        rxd    = 1'b1;
        rd_en  = 1'b0;
        test_reset();
        test_single_frame();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_push_with_pop();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
